// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register: command opcodes, controller
// states and opcode classification helpers.
package shreg_pkg;

    // All eight opcode values are in use, so ASR occupies 3'b111.
    typedef enum logic [2:0] {
        NOP  = 3'd0,
        LOAD = 3'd1,
        CLR  = 3'd2,
        SHR  = 3'd3,
        SHL  = 3'd4,
        ROR  = 3'd5,
        ROL  = 3'd6,
        ASR  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_shift(op_e op);
        return (op == SHR) || (op == SHL) || (op == ROR) || (op == ROL) || (op == ASR);
    endfunction

    function automatic logic moves_right(op_e op);
        return (op == SHR) || (op == ROR) || (op == ASR);
    endfunction

endpackage

// File: rtl/shreg_cell.sv
// One bit of the universal shift register: next-value mux (hold, load, take
// left or right neighbour) feeding an async-reset flip-flop.
module shreg_cell (
    input  logic clk,
    input  logic areset_n,
    input  logic hold,
    input  logic load_en,
    input  logic take_left,
    input  logic left_nb,
    input  logic right_nb,
    input  logic load_bit,
    output logic q
);

    logic d;

    assign d = hold      ? q        :
               load_en   ? load_bit :
               take_left ? left_nb  : right_nb;

    // NOTE: flops use non-blocking assignments so every bit samples its
    // neighbour's pre-edge value; blocking here would ripple a shift in one edge.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) q <= 1'b0;
        else           q <= d;
    end

endmodule

// File: rtl/univ_shift_register.sv
// Universal WIDTH-bit shift register with a valid/ready command controller.
// Optional registered parity output q_parity when SHREG_PARITY_EN is defined.
module univ_shift_register
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
`ifdef SHREG_PARITY_EN
    ,
    output logic             q_parity
`endif
);

    state_e           state_q, state_d;
    op_e              op_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ld_q;
    logic             hold, load_en, take_left;
    logic             fill_msb, fill_lsb;
    logic [WIDTH-1:0] load_vec;
    logic [WIDTH+1:0] ext;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
            op_q    <= NOP;
            cnt_q   <= '0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && cmd_valid) begin
                op_q <= op_e'(cmd_op);
                ld_q <= load_data;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        hold      = 1'b1;
        load_en   = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = RUN;
                    cnt_d   = cmd_count;
                end
            end
            RUN: begin
                busy    = 1'b1;
                state_d = DONE;
                if (op_q == LOAD || op_q == CLR) begin
                    hold    = 1'b0;
                    load_en = 1'b1;
                end else if (is_shift(op_q) && cnt_q != '0) begin
                    hold  = 1'b0;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q != CNT_W'(1)) state_d = RUN;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge fill: rotates recirculate, ASR repeats the sign, plain shifts take serial input.
    assign fill_msb  = (op_q == ROR) ? q[0] : (op_q == ASR) ? q[WIDTH-1] : ser_in_l;
    assign fill_lsb  = (op_q == ROL) ? q[WIDTH-1] : ser_in_r;
    assign take_left = moves_right(op_q);
    assign load_vec  = (op_q == LOAD) ? ld_q : '0;
    assign ext       = {fill_msb, q, fill_lsb};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        shreg_cell u_cell (
            .clk       (clk),
            .areset_n  (areset_n),
            .hold      (hold),
            .load_en   (load_en),
            .take_left (take_left),
            .left_nb   (ext[i+2]),
            .right_nb  (ext[i]),
            .load_bit  (load_vec[i]),
            .q         (q[i])
        );
    end

    assign ser_out_l = q[WIDTH-1];
    assign ser_out_r = q[0];

`ifdef SHREG_PARITY_EN
    logic [WIDTH-1:0] q_next;

    assign q_next = hold      ? q             :
                    load_en   ? load_vec      :
                    take_left ? ext[WIDTH+1:2] : ext[WIDTH-1:0];

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) q_parity <= 1'b0;
        else           q_parity <= ^q_next;
    end
`endif

endmodule
